// File: rtl/alu_acumulador_pkg.sv
// Shared types and op_code encodings for the ALU/accumulator stage.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // op_code[1:0] meaning when ctl_arith=1
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // op_code[1:0] meaning when ctl_arith=0
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam int OP_CARRY_BIT = 3;

endpackage

// File: rtl/alu_acumulador_if.sv
// Command/status bundle between the decode table, this stage and the display driver.
interface alu_acumulador_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic [3:0]       op_code;
  logic             ctl_rst;
  logic             ctl_load;
  logic             ctl_arith;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             overrun;
  logic             busy;
  logic             valid;

  modport master (
    output tick, op_code, ctl_rst, ctl_load, ctl_arith, operand,
    input  acc, zero, carry, overflow, overrun, busy, valid
  );

  modport slave (
    input  tick, op_code, ctl_rst, ctl_load, ctl_arith, operand,
    output acc, zero, carry, overflow, overrun, busy, valid
  );
endinterface

// File: rtl/alu_acumulador_nucleo.sv
// Combinational ALU core: one add/sub or bitwise op on acc and operand.
module alu_nucleo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [3:0]       op_i,
  input  logic             arith_i,
  input  logic             carry_i,
  output logic [WIDTH:0]   res_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] rhs;
  logic             extra;
  logic             subtract;
  logic             unusedOpBit;

  // op_code[2] carries no meaning for this stage
  assign unusedOpBit = op_i[2];

  always_comb begin
    rhs        = operand_i;
    extra      = 1'b0;
    subtract   = 1'b0;
    res_o      = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    if (arith_i) begin
      case (op_i[1:0])
        OP_ADD: extra = op_i[OP_CARRY_BIT] & carry_i;
        OP_SUB: begin
          extra    = op_i[OP_CARRY_BIT] & carry_i;
          subtract = 1'b1;
        end
        OP_INC: rhs = WIDTH'(1);
        default: begin
          rhs      = WIDTH'(1);
          subtract = 1'b1;
        end
      endcase
      // The extra MSB turns into carry-out on add and borrow on subtract
      if (subtract)
        res_o = {1'b0, acc_i} - {1'b0, rhs} - {{WIDTH{1'b0}}, extra};
      else
        res_o = {1'b0, acc_i} + {1'b0, rhs} + {{WIDTH{1'b0}}, extra};
      carry_o    = res_o[WIDTH];
      overflow_o = ((acc_i[WIDTH-1] ^ rhs[WIDTH-1]) == subtract) &&
                   (res_o[WIDTH-1] != acc_i[WIDTH-1]);
    end else begin
      case (op_i[1:0])
        OP_AND:  res_o = {1'b0, acc_i & operand_i};
        OP_OR:   res_o = {1'b0, acc_i | operand_i};
        OP_XOR:  res_o = {1'b0, acc_i ^ operand_i};
        default: res_o = {1'b0, ~acc_i};
      endcase
    end
  end

endmodule

// File: rtl/alu_acumulador.sv
// Accumulator stage: accepts one command per idle tick, executes it over
// EXEC/WRITE and pulses valid when acc and flags change.
module alu_acumulador
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  alu_acumulador_if.slave  bus
);

  state_e           state_q, state_d;
  logic [3:0]       opCode_q, opCode_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             arith_q, arith_d;
  logic [WIDTH:0]   res_q, res_d;
  logic             resOvf_q, resOvf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   aluRes;
  logic             aluCarry;
  logic             aluOvf;
  logic             unusedAluCarry;

  // Carry travels inside res_q[WIDTH], so the separate carry output is redundant here
  assign unusedAluCarry = aluCarry;

  alu_nucleo #(.WIDTH(WIDTH)) u_nucleo (
    .acc_i      (acc_q),
    .operand_i  (operand_q),
    .op_i       (opCode_q),
    .arith_i    (arith_q),
    .carry_i    (carry_q),
    .res_o      (aluRes),
    .carry_o    (aluCarry),
    .overflow_o (aluOvf)
  );

  always_comb begin
    state_d   = state_q;
    opCode_d  = opCode_q;
    operand_d = operand_q;
    arith_d   = arith_q;
    res_d     = res_q;
    resOvf_d  = resOvf_q;
    acc_d     = acc_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tick && bus.ctl_load) begin
          opCode_d  = bus.op_code;
          operand_d = bus.operand;
          arith_d   = bus.ctl_arith;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d    = aluRes;
        resOvf_d = aluOvf;
        state_d  = WRITE;
      end
      WRITE: begin
        acc_d   = res_q[WIDTH-1:0];
        zero_d  = (res_q[WIDTH-1:0] == '0);
        carry_d = res_q[WIDTH];
        ovf_d   = resOvf_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.tick && (state_q != IDLE))
      overrun_d = 1'b1;

    // A clear strobe wins over everything, including an in-flight write
    if (bus.tick && bus.ctl_rst) begin
      state_d   = IDLE;
      acc_d     = '0;
      zero_d    = 1'b0;
      carry_d   = 1'b0;
      ovf_d     = 1'b0;
      overrun_d = 1'b0;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opCode_q  <= '0;
      operand_q <= '0;
      arith_q   <= 1'b0;
      res_q     <= '0;
      resOvf_q  <= 1'b0;
      acc_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      opCode_q  <= opCode_d;
      operand_q <= operand_d;
      arith_q   <= arith_d;
      res_q     <= res_d;
      resOvf_q  <= resOvf_d;
      acc_q     <= acc_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.acc      = acc_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.overrun  = overrun_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_acumulador.sv
// Scoreboard bench for alu_acumulador: integer reference model feeds an
// expectation queue that a negedge monitor drains on every valid pulse.
module tb_alu_acumulador;

  localparam int W = 8;

  typedef struct {
    int due;
    int acc;
    int zero;
    int carry;
    int ovf;
    int overrun;
  } exp_t;

  logic clk;
  logic reset;

  alu_acumulador_if #(.WIDTH(W)) bus ();

  alu_acumulador #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t expQ[$];
  int   asserts  = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   expBusy  = 1'b0;

  // Reference model: architectural state plus a pending result and its remaining latency
  int mAcc, mZero, mCarry, mOvf, mOverrun;
  int pendStage;
  int pAcc, pCarry, pOvf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, int act, int exp);
    asserts++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int toSigned(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic void computeResult(int op, int arith, int b);
    int a, cin, s, ss;
    a   = mAcc;
    cin = (((op >> 3) & 1) != 0) ? mCarry : 0;
    s   = 0;
    ss  = 0;
    if (arith != 0) begin
      case (op & 3)
        0: begin s = a + b + cin; ss = toSigned(a) + toSigned(b) + cin; pCarry = (s > 255) ? 1 : 0; end
        1: begin s = a - b - cin; ss = toSigned(a) - toSigned(b) - cin; pCarry = (s < 0) ? 1 : 0; end
        2: begin s = a + 1; ss = toSigned(a) + 1; pCarry = (s > 255) ? 1 : 0; end
        default: begin s = a - 1; ss = toSigned(a) - 1; pCarry = (s < 0) ? 1 : 0; end
      endcase
      pAcc = s & 255;
      pOvf = (ss > 127 || ss < -128) ? 1 : 0;
    end else begin
      case (op & 3)
        0: pAcc = a & b;
        1: pAcc = a | b;
        2: pAcc = a ^ b;
        default: pAcc = (~a) & 255;
      endcase
      pCarry = 0;
      pOvf   = 0;
    end
  endfunction

  function automatic void modelClear();
    mAcc = 0; mZero = 0; mCarry = 0; mOvf = 0; mOverrun = 0;
    pendStage = 0;
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, then step past it
  task automatic applyStimulus(bit t, bit r, bit ld, bit ar, logic [3:0] op, logic [7:0] opnd);
    int nextStage;
    bus.tick      = t;
    bus.ctl_rst   = r;
    bus.ctl_load  = ld;
    bus.ctl_arith = ar;
    bus.op_code   = op;
    bus.operand   = opnd;
    nextStage = pendStage;
    if (t && r) begin
      modelClear();
      expQ.push_back(exp_t'{cyc + 1, 0, 0, 0, 0, 0});
      nextStage = 0;
    end else begin
      if (t && pendStage != 0) mOverrun = 1;
      if (pendStage == 1) begin
        mAcc = pAcc; mCarry = pCarry; mOvf = pOvf;
        mZero = (pAcc == 0) ? 1 : 0;
        expQ.push_back(exp_t'{cyc + 1, mAcc, mZero, mCarry, mOvf, mOverrun});
        nextStage = 0;
      end else if (pendStage == 2) begin
        nextStage = 1;
      end else if (t && ld) begin
        computeResult(int'(op), int'(ar), int'(opnd));
        nextStage = 2;
      end
    end
    pendStage = nextStage;
    @(posedge clk);
    #1;
    expBusy = (pendStage != 0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
  endtask

  task automatic doCmd(logic [3:0] op, bit ar, logic [7:0] opnd);
    applyStimulus(1'b1, 1'b0, 1'b1, ar, op, opnd);
    repeat (3) idleCycle();
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_acc"}, int'(bus.acc), 0);
    checkOutput({tag, "_zero"}, int'(bus.zero), 0);
    checkOutput({tag, "_carry"}, int'(bus.carry), 0);
    checkOutput({tag, "_ovf"}, int'(bus.overflow), 0);
    checkOutput({tag, "_overrun"}, int'(bus.overrun), 0);
    checkOutput({tag, "_valid"}, int'(bus.valid), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Monitor: busy every cycle, full result against the queue on each valid pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checkOutput("busy", int'(bus.busy), int'(expBusy));
      if (bus.valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", int'(bus.valid), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("validCycle", cyc, e.due);
          checkOutput("acc", int'(bus.acc), e.acc);
          checkOutput("zero", int'(bus.zero), e.zero);
          checkOutput("carry", int'(bus.carry), e.carry);
          checkOutput("overflow", int'(bus.overflow), e.ovf);
          checkOutput("overrun", int'(bus.overrun), e.overrun);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.ctl_rst   = 1'b0;
    bus.ctl_load  = 1'b0;
    bus.ctl_arith = 1'b0;
    bus.op_code   = 4'h0;
    bus.operand   = 8'h00;
    modelClear();
    #3;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    doCmd(4'b0000, 1'b1, 8'h05);
    checkOutput("plan_add05", int'(bus.acc), 8'h05);

    doCmd(4'b0100, 1'b0, 8'h00);
    doCmd(4'b0000, 1'b1, 8'h7F);
    doCmd(4'b0000, 1'b1, 8'h01);
    checkOutput("plan_7f_plus1", int'(bus.acc), 8'h80);
    checkOutput("plan_7f_plus1_ovf", int'(bus.overflow), 1);
    doCmd(4'b0000, 1'b1, 8'h80);
    checkOutput("plan_80_plus80", int'(bus.acc), 8'h00);
    checkOutput("plan_80_plus80_carry", int'(bus.carry), 1);
    checkOutput("plan_80_plus80_zero", int'(bus.zero), 1);

    doCmd(4'b0100, 1'b0, 8'h00);
    doCmd(4'b0000, 1'b1, 8'h03);
    doCmd(4'b0001, 1'b1, 8'h05);
    checkOutput("plan_sub", int'(bus.acc), 8'hFE);
    checkOutput("plan_sub_borrow", int'(bus.carry), 1);
    doCmd(4'b1001, 1'b1, 8'h00);
    checkOutput("plan_sbb", int'(bus.acc), 8'hFD);
    checkOutput("plan_sbb_borrow", int'(bus.carry), 0);
    doCmd(4'b0100, 1'b0, 8'h00);
    doCmd(4'b0011, 1'b1, 8'h5A);
    checkOutput("plan_dec", int'(bus.acc), 8'hFF);
    checkOutput("plan_dec_borrow", int'(bus.carry), 1);

    doCmd(4'b0100, 1'b0, 8'h00);
    doCmd(4'b0000, 1'b1, 8'hF0);
    doCmd(4'b0101, 1'b0, 8'h0F);
    checkOutput("plan_or", int'(bus.acc), 8'hFF);
    doCmd(4'b0100, 1'b0, 8'h00);
    checkOutput("plan_and_zero", int'(bus.zero), 1);

    // Second tick one cycle after acceptance is dropped and flagged
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h22);
    repeat (3) idleCycle();
    checkOutput("plan_overrun", int'(bus.overrun), 1);
    checkOutput("plan_overrun_acc", int'(bus.acc), 8'h01);

    // Clear strobe one cycle after acceptance aborts the operation
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h05);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00);
    checkOutput("plan_abort_acc", int'(bus.acc), 0);
    checkOutput("plan_abort_overrun", int'(bus.overrun), 0);
    checkOutput("plan_abort_valid", int'(bus.valid), 1);
    repeat (4) idleCycle();

    // Asynchronous reset while the command sits in EXEC
    doCmd(4'b0000, 1'b1, 8'h33);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h11);
    bus.tick = 1'b0;
    #2;
    reset   = 1'b1;
    expBusy = 1'b0;
    #1;
    checkAllZero("asyncReset");
    modelClear();
    @(posedge clk);
    #1;
    reset = 1'b0;

    doCmd(4'b0000, 1'b1, 8'h44);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h55);
    repeat (3) idleCycle();
    checkOutput("plan_noload_acc", int'(bus.acc), 8'h44);

    repeat (400) begin
      applyStimulus(1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) != 0),
                    1'($urandom), 4'($urandom), 8'($urandom));
    end

    repeat (4) idleCycle();
    @(negedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
